// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface.
//   req        : level request per bus source (requesters -> arbiter)
//   grant      : registered one-hot (or zero) mux source select
//   grantValid : grant is non-zero
//   grantIdx   : binary index of current owner, 0 when no owner
//   holdCount  : cycles the current owner has held the bus (saturating)
// master = requester side, slave = arbiter side.
interface bus_source_arbiter_if #(
  parameter int REGISTERS = 22,
  parameter int IDXW      = 5
);
  logic [REGISTERS-1:0] req;
  logic [REGISTERS-1:0] grant;
  logic                 grantValid;
  logic [IDXW-1:0]      grantIdx;
  logic [2:0]           holdCount;

  modport master (output req, input grant, grantValid, grantIdx, holdCount);
  modport slave  (input req, output grant, grantValid, grantIdx, holdCount);
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared 32-bit bus mux source select.
// Grants one requester at a time, forces a hand-off after MAX_HOLD cycles
// when someone else is waiting, and leaves one dead (no-driver) cycle
// between consecutive owners.
//   clk : clock, rising edge
//   clr : synchronous active-high reset
//   bus : slave side of bus_source_arbiter_if (req in; grant, grantValid,
//         grantIdx, holdCount out, all registered)
module bus_source_arbiter #(
  parameter int REGISTERS = 22,
  parameter int MAX_HOLD  = 4,
  parameter int IDXW      = 5
) (
  input  logic                    clk,
  input  logic                    clr,
  bus_source_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDXW-1:0]      r_ptr, w_ptr_nxt;
  logic [REGISTERS-1:0] r_grant, w_grant_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [IDXW-1:0]      r_idx, w_idx_nxt;
  logic [2:0]           r_hold, w_hold_nxt;

  logic [IDXW-1:0]      w_pick;
  logic [REGISTERS-1:0] w_pick_oh;
  logic                 w_any_req;
  logic                 w_others;
  logic [IDXW-1:0]      w_ptr_after;

  // Rotating priority scan starting at r_ptr.
  always_comb begin
    int  idx;
    logic found;
    w_pick = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < REGISTERS; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= REGISTERS) idx = idx - REGISTERS;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        w_pick = IDXW'(idx);
      end
    end
  end

  assign w_pick_oh   = {{(REGISTERS-1){1'b0}}, 1'b1} << w_pick;
  assign w_any_req   = |bus.req;
  assign w_others    = |(bus.req & ~r_grant);
  // Pointer moves just past the outgoing owner so it is served last.
  assign w_ptr_after = (int'(r_idx) == REGISTERS-1) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE, TURN: begin
        // TURN is the single dead cycle; its pick already sees the new ptr.
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_idx_nxt   = '0;
        w_hold_nxt  = '0;
        w_state_nxt = IDLE;
        if (w_any_req) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_oh;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = w_pick;
          w_hold_nxt  = 3'd1;
        end
      end
      GRANT: begin
        if (!bus.req[r_idx] ||
            ((r_hold >= 3'(MAX_HOLD)) && w_others)) begin
          w_state_nxt = TURN;
          w_ptr_nxt   = w_ptr_after;
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_hold_nxt  = '0;
        end else if (r_hold < 3'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_idx_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.grantValid = r_valid;
  assign bus.grantIdx   = r_idx;
  assign bus.holdCount  = r_hold;

endmodule

// File: tb/tb_bus_source_arbiter.sv
module tb_bus_source_arbiter;
  localparam int R  = 22;
  localparam int MH = 4;
  localparam int IW = 5;
  localparam int STARVE = R * (MH + 1);

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  bus_source_arbiter_if #(.REGISTERS(R), .IDXW(IW)) bus ();

  bus_source_arbiter #(.REGISTERS(R), .MAX_HOLD(MH), .IDXW(IW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, for how long, where the scan starts.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  // Property trackers.
  logic [R-1:0] prev_grant = '0;
  logic [R-1:0] run_g = '0;
  int run_len = 0;
  int waitc [R];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) begin
      if (r[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  task automatic model(input logic [R-1:0] r, input logic c);
    logic [R-1:0] others;
    if (c) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (m_hold >= MH && others != '0)) begin
        m_ptr = (m_owner + 1) % R;
        m_owner = -1;
        m_hold = 0;
      end else begin
        m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
      end
    end else if (r != '0) begin
      // Reached from idle or from the dead cycle.
      m_owner = pick(r, m_ptr);
      m_hold = 1;
    end
  endtask

  task automatic step(input logic [R-1:0] r, input logic c);
    logic [R-1:0] eg;
    logic [R-1:0] pre_g;
    int mx;
    bus.req = r;
    clr = c;
    pre_g = bus.grant;
    @(posedge clk);
    #1;
    model(r, c);
    eg = (m_owner >= 0) ? (R'(1) << m_owner) : '0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("grantValid", 32'(bus.grantValid), 32'(m_owner >= 0));
    chk("grantIdx", 32'(bus.grantIdx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("holdCount", 32'(bus.holdCount), 32'(m_hold));
    chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    // Owner change must pass through an all-zero cycle.
    if (prev_grant != '0 && bus.grant != '0)
      chk("deadcycle", 32'(bus.grant), 32'(prev_grant));
    prev_grant = bus.grant;
    // Tenure while others wait, counted over the cycle just ended.
    if (!c && pre_g != '0 && (r & ~pre_g) != '0) begin
      if (pre_g == run_g) run_len++;
      else begin run_g = pre_g; run_len = 1; end
    end else begin
      run_len = 0; run_g = '0;
    end
    chk("tenure_ok", 32'(run_len <= MH), 32'd1);
    mx = 0;
    for (int i = 0; i < R; i++) begin
      if (!c && r[i] && !bus.grant[i]) waitc[i]++;
      else waitc[i] = 0;
      if (waitc[i] > mx) mx = waitc[i];
    end
    chk("starve_ok", 32'(mx <= STARVE), 32'd1);
  endtask

  initial begin
    logic [R-1:0] rq;
    int exp_t3 [11];
    for (int i = 0; i < R; i++) waitc[i] = 0;
    bus.req = '0;

    // T1 reset with every source requesting.
    step({R{1'b1}}, 1'b1);
    chk("t1_grant", 32'(bus.grant), 32'd0);
    chk("t1_idx", 32'(bus.grantIdx), 32'd0);
    chk("t1_valid", 32'(bus.grantValid), 32'd0);
    step({R{1'b1}}, 1'b0);
    chk("t1_r0", 32'(bus.grant), 32'h1);
    step('0, 1'b0);
    step('0, 1'b0);

    // T2 single requester holds indefinitely, holdCount saturates.
    for (int k = 0; k < 10; k++) begin
      step(R'(1) << 5, 1'b0);
      chk("t2_grant", 32'(bus.grant), 32'h20);
      chk("t2_hold", 32'(bus.holdCount), (k + 1 > MH) ? 32'(MH) : 32'(k + 1));
    end
    step('0, 1'b0);
    chk("t2_turn", 32'(bus.grant), 32'd0);
    step('0, 1'b0);
    chk("t2_idle", 32'(bus.grantValid), 32'd0);

    // T3 preemption between r3 and r7.
    step('0, 1'b1);
    exp_t3 = '{3, 3, 3, 3, -1, 7, 7, 7, 7, -1, 3};
    for (int k = 0; k < 11; k++) begin
      step((R'(1) << 3) | (R'(1) << 7), 1'b0);
      chk("t3_grant", 32'(bus.grant), (exp_t3[k] < 0) ? 32'd0 : (32'd1 << exp_t3[k]));
    end
    step('0, 1'b0);
    step('0, 1'b0);

    // T4 pointer wrap: r20 releases, r21 then r0.
    step('0, 1'b1);
    step(R'(1) << 20, 1'b0);
    chk("t4_r20", 32'(bus.grant), 32'h10_0000);
    step((R'(1) << 21) | R'(1), 1'b0);
    chk("t4_dead1", 32'(bus.grant), 32'd0);
    step((R'(1) << 21) | R'(1), 1'b0);
    chk("t4_r21", 32'(bus.grant), 32'h20_0000);
    step(R'(1), 1'b0);
    chk("t4_dead2", 32'(bus.grant), 32'd0);
    step(R'(1), 1'b0);
    chk("t4_r0", 32'(bus.grant), 32'h1);
    step('0, 1'b0);
    step('0, 1'b0);

    // T5 mid-grant reset; ptr must return to 0 (r16 beats r20 afterwards).
    step(R'(1) << 16, 1'b0);
    step('0, 1'b0);
    step(R'(1) << 16, 1'b0);
    step(R'(1) << 16, 1'b0);
    chk("t5_hold2", 32'(bus.holdCount), 32'd2);
    step((R'(1) << 16) | (R'(1) << 20), 1'b1);
    chk("t5_clr_grant", 32'(bus.grant), 32'd0);
    chk("t5_clr_hold", 32'(bus.holdCount), 32'd0);
    step((R'(1) << 16) | (R'(1) << 20), 1'b0);
    chk("t5_regrant", 32'(bus.grant), 32'h1_0000);
    chk("t5_hold1", 32'(bus.holdCount), 32'd1);

    // T6 random sticky requests with rare resets.
    rq = '0;
    for (int n = 0; n < 10000; n++) begin
      rq = rq ^ R'($urandom & $urandom & $urandom);
      step(rq, ($urandom_range(499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
